// File: rtl/led_pll_pkg.sv
// led_pll_pkg: shared state encoding and PLL configuration defaults for the LED-driver PLL controller.
package led_pll_pkg;

    typedef enum logic [2:0] {RST_HOLD, WAIT_LOCK, STABLE, READY, SETTLE, FAIL} pll_state_e;

    localparam logic [3:0] PSDA_DEF = 4'b0000;
    localparam logic [3:0] DUTY_DEF = 4'b1000;
    localparam logic [3:0] FDLY_DEF = 4'b0000;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        return m > d ? m : d;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop single-bit synchronizer with asynchronous active-low clear.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {q, meta} <= 2'b00;
        else        {q, meta} <= {meta, d};

endmodule

// File: rtl/led_pll_ctrl.sv
// led_pll_ctrl: rPLL reset/lock sequencer with runtime PSDA/DUTYDA/FDLY updates and bounded relock retries.
module led_pll_ctrl import led_pll_pkg::*; #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 256,
    parameter int SETTLE_CYCLES = 32,
    parameter int RETRY_MAX     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [3:0] cfg_psda,
    input  logic [3:0] cfg_dutyda,
    input  logic [3:0] cfg_fdly,
    input  logic       cfg_relock,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic [3:0] pll_psda,
    output logic [3:0] pll_dutyda,
    output logic [3:0] pll_fdly,
    output logic       pll_ready,
    output logic       err_fail,
    output logic [7:0] lock_loss_cnt
);

    localparam int CW = $clog2(max4(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, SETTLE_CYCLES) + 1);
    localparam int RW = $clog2(RETRY_MAX + 1) + 1;

    pll_state_e    state, nxt;
    logic [CW-1:0] cnt;
    logic [RW-1:0] retry, retry_n;
    logic          lock_s, drop, accept, cfg_rdy_q;

    sync_2ff u_lock_sync (.clk(clk), .rst_n(rst_n), .d(pll_lock), .q(lock_s));

    // A lock fall in READY/SETTLE outranks any request in the same cycle.
    always_comb begin
        drop      = (state == READY || state == SETTLE) && !lock_s;
        cfg_ready = cfg_rdy_q && !drop;
        accept    = cfg_valid && cfg_ready;
        nxt       = state;
        retry_n   = retry;
        unique case (state)
            RST_HOLD:  if (cnt == CW'(RST_CYCLES - 1)) nxt = WAIT_LOCK;
            WAIT_LOCK:
                if (lock_s) nxt = STABLE;
                else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                    retry_n = retry + RW'(1);
                    nxt     = retry_n >= RW'(RETRY_MAX) ? FAIL : RST_HOLD;
                end
            STABLE:
                if (!lock_s) nxt = WAIT_LOCK;
                else if (cnt == CW'(STABLE_CYCLES - 1)) begin
                    nxt     = READY;
                    retry_n = '0;
                end
            READY:
                if (drop) nxt = RST_HOLD;
                else if (accept) nxt = cfg_relock ? RST_HOLD : SETTLE;
            SETTLE:
                if (drop) nxt = RST_HOLD;
                else if (cnt == CW'(SETTLE_CYCLES - 1)) nxt = READY;
            FAIL:
                if (accept) begin
                    nxt     = RST_HOLD;
                    retry_n = '0;
                end
            default: nxt = RST_HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state         <= RST_HOLD;
            cnt           <= '0;
            retry         <= '0;
            pll_reset     <= 1'b1;
            pll_ready     <= 1'b0;
            cfg_rdy_q     <= 1'b0;
            err_fail      <= 1'b0;
            lock_loss_cnt <= 8'd0;
            pll_psda      <= PSDA_DEF;
            pll_dutyda    <= DUTY_DEF;
            pll_fdly      <= FDLY_DEF;
        end else begin
            state     <= nxt;
            cnt       <= nxt != state ? '0 : cnt + CW'(1);
            retry     <= retry_n;
            pll_reset <= nxt == RST_HOLD || nxt == FAIL;
            pll_ready <= nxt == READY;
            cfg_rdy_q <= nxt == READY || nxt == FAIL;
            err_fail  <= err_fail || nxt == FAIL;
            if (drop && lock_loss_cnt != 8'hff) lock_loss_cnt <= lock_loss_cnt + 8'd1;
            if (accept) begin
                pll_psda   <= cfg_psda;
                pll_dutyda <= cfg_dutyda;
                pll_fdly   <= cfg_fdly;
            end
        end

endmodule

// File: tb/tb_led_pll_ctrl.sv
// tb_led_pll_ctrl: directed-step bench for led_pll_ctrl with hand-computed cycle counts.
module tb_led_pll_ctrl;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cfg_valid = 1'b0, cfg_relock = 1'b0, pll_lock = 1'b0;
    logic [3:0] cfg_psda = 4'h0, cfg_dutyda = 4'h0, cfg_fdly = 4'h0;
    logic       cfg_ready, pll_reset, pll_ready, err_fail;
    logic [3:0] pll_psda, pll_dutyda, pll_fdly;
    logic [7:0] lock_loss_cnt;
    int         total = 0, bad = 0, n;
    logic       seen;

    always #5 clk = ~clk;

    led_pll_ctrl #(.LOCK_TIMEOUT(400)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_psda(cfg_psda), .cfg_dutyda(cfg_dutyda), .cfg_fdly(cfg_fdly),
        .cfg_relock(cfg_relock), .pll_lock(pll_lock), .pll_reset(pll_reset),
        .pll_psda(pll_psda), .pll_dutyda(pll_dutyda), .pll_fdly(pll_fdly),
        .pll_ready(pll_ready), .err_fail(err_fail), .lock_loss_cnt(lock_loss_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [3:0] p, input logic [3:0] d, input logic [3:0] f, input logic rl);
        cfg_valid = 1'b1; cfg_psda = p; cfg_dutyda = d; cfg_fdly = f; cfg_relock = rl;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic reset_high_len(output int k);
        k = 0;
        while (pll_reset === 1'b1 && k < 2000) begin k++; @(negedge clk); end
    endtask

    task automatic reset_low_len(output int k);
        k = 0;
        while (pll_reset === 1'b0 && k < 2000) begin k++; @(negedge clk); end
    endtask

    task automatic ready_low_len(output int k);
        k = 0;
        while (pll_ready !== 1'b1 && k < 2000) begin k++; @(negedge clk); end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_pll_reset", pll_reset, 1);
        chk("rst_pll_ready", pll_ready, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_err_fail", err_fail, 0);
        chk("rst_loss_cnt", lock_loss_cnt, 0);
        chk("rst_psda", pll_psda, 4'b0000);
        chk("rst_dutyda", pll_dutyda, 4'b1000);
        chk("rst_fdly", pll_fdly, 4'b0000);
        rst_n = 1'b1;
        reset_high_len(n);
        chk("pwrup_reset_len", n, 16);
        repeat (84) @(negedge clk);
        pll_lock = 1'b1;
        ready_low_len(n);
        chk("lock_to_ready", n, 259);
        chk("ready_cfg_ready", cfg_ready, 1);
        chk("ready_err_fail", err_fail, 0);

        req(4'b0101, 4'h3, 4'h9, 1'b0);
        chk("upd_psda", pll_psda, 4'b0101);
        chk("upd_dutyda", pll_dutyda, 4'h3);
        chk("upd_fdly", pll_fdly, 4'h9);
        chk("upd_ready_low", pll_ready, 0);
        chk("upd_cfg_ready_low", cfg_ready, 0);
        n = 0; seen = 1'b0;
        while (pll_ready !== 1'b1 && n < 2000) begin seen |= pll_reset; n++; @(negedge clk); end
        chk("settle_len", n, 32);
        chk("settle_no_reset", seen, 0);

        req(4'hA, 4'h6, 4'h2, 1'b1);
        chk("relock_reset", pll_reset, 1);
        chk("relock_ready_low", pll_ready, 0);
        chk("relock_psda", pll_psda, 4'hA);
        reset_high_len(n);
        chk("relock_reset_len", n, 16);
        ready_low_len(n);
        chk("relock_to_ready", n, 257);

        pll_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("drop_ready_still", pll_ready, 1);
        chk("drop_cfg_ready_gated", cfg_ready, 0);
        cfg_valid = 1'b1; cfg_psda = 4'hF; cfg_relock = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("drop_loss_cnt", lock_loss_cnt, 1);
        chk("drop_reset", pll_reset, 1);
        chk("drop_ready_low", pll_ready, 0);
        chk("drop_req_ignored", pll_psda, 4'hA);
        repeat (2) @(negedge clk);
        pll_lock = 1'b1;
        ready_low_len(n);
        chk("drop_recovered", pll_ready, 1);
        chk("drop_loss_hold", lock_loss_cnt, 1);

        req(4'h1, 4'h8, 4'h0, 1'b1);
        reset_high_len(n);
        repeat (100) @(negedge clk);
        chk("stable_not_ready", pll_ready, 0);
        pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        pll_lock = 1'b1;
        ready_low_len(n);
        chk("glitch_restart", n, 259);

        req(4'h7, 4'h7, 4'h7, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_settle_reset", pll_reset, 1);
        chk("arst_settle_ready", pll_ready, 0);
        chk("arst_settle_psda", pll_psda, 4'h0);
        chk("arst_settle_duty", pll_dutyda, 4'h8);
        chk("arst_settle_fdly", pll_fdly, 4'h0);
        chk("arst_settle_loss", lock_loss_cnt, 0);
        pll_lock = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        chk("wait_lock_reset_low", pll_reset, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wait_reset", pll_reset, 1);
        chk("arst_wait_cfg_ready", cfg_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;

        n = 0;
        while (err_fail !== 1'b1 && n < 5000) begin n++; @(negedge clk); end
        chk("fail_after_3_timeouts", n, 1248);
        chk("fail_cfg_ready", cfg_ready, 1);
        chk("fail_reset", pll_reset, 1);
        chk("fail_ready", pll_ready, 0);
        repeat (5) @(negedge clk);
        chk("fail_held", pll_reset, 1);

        req(4'h3, 4'h8, 4'h0, 1'b0);
        chk("fail_exit_sticky", err_fail, 1);
        chk("fail_exit_cfg_ready", cfg_ready, 0);
        chk("fail_exit_psda", pll_psda, 4'h3);
        reset_high_len(n);
        chk("fail_exit_reset_len", n, 16);
        reset_low_len(n);
        chk("retry_timeout_len", n, 400);
        reset_high_len(n);
        chk("retry_cleared", n, 16);
        chk("final_sticky", err_fail, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
